// File: rtl/full_receiver.sv
// full_receiver: rebuilds one 32-bit word from four back-to-back 10-bit RxD frames
// ({start=0, 8 data bits MSB-first, stop=1}), MSB byte first.
// Optional feature macro RX_SYNC_EN: passes RxD through a 2-flop synchronizer first.
module full_receiver #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RxD,
  output logic [31:0] data,
  output logic        valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [23:0]      word_q, word_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             armed_q, armed_d;
  logic             busy_q;
  logic             rxd;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], RxD};
  end

  assign rxd = sync_q[1];
`else
  assign rxd = RxD;
`endif

  // Next-state logic; counter values hold "cycles remaining minus one".
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    word_d      = word_q;
    data_d      = data_q;
    armed_d     = armed_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!armed_q) begin
          if (rxd) armed_d = 1'b1;
        end else if (!rxd) begin
          bit_cnt_d = '0;
          if (CLKS_PER_BIT == 1) begin
            // The detect cycle is already the start-bit sample.
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            state_d = START;
            cnt_d   = CNT_W'(HALF_BIT - 1);
          end
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rxd) begin
          state_d = IDLE;
        end else begin
          state_d   = DATA;
          cnt_d     = CNT_W'(CLKS_PER_BIT - 1);
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d     = CNT_W'(CLKS_PER_BIT - 1);
          shift_d   = {shift_q[6:0], rxd};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          if (rxd) begin
            if (byte_cnt_q == 2'd3) begin
              data_d     = {word_q, shift_q};
              valid_d    = 1'b1;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              unique case (byte_cnt_q)
                2'd0:    word_d[23:16] = shift_q;
                2'd1:    word_d[15:8]  = shift_q;
                default: word_d[7:0]   = shift_q;
              endcase
            end
          end else begin
            // Bad stop bit: drop the partial word and wait for the line to go high.
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
            word_d      = '0;
            armed_d     = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_full_receiver.sv
// Bench for full_receiver: one instance at 1 clk/bit, one at 16 clks/bit.
module tb_full_receiver;

`ifdef RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int N16 = 16;
  localparam int NV  = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rxd1, valid1, ferr1, busy1;
  logic [31:0] data1;
  logic        rst16, rxd16, valid16, ferr16, busy16;
  logic [31:0] data16;

  full_receiver #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(rst1), .RxD(rxd1), .data(data1),
    .valid(valid1), .frame_err(ferr1), .busy(busy1));

  full_receiver #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .reset(rst16), .RxD(rxd16), .data(data16),
    .valid(valid16), .frame_err(ferr16), .busy(busy16));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endfunction

  // Frame-level reference model for the 1 clk/bit instance.
  logic [7:0]  mbytes[$];
  int          exp_kind[int];
  logic [31:0] exp_word[int];
  logic [31:0] exp_last = '0;
  int          nexp = 0;

  int          got_kind[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  logic [31:0] prev_data1 = '0;

  // Cycle-accurate scoreboard for the 1 clk/bit instance.
  always @(negedge clk) begin : mon1
    int k;
    k = exp_kind.exists(cyc) ? exp_kind[cyc] : 0;
    if (valid1 === 1'b1 || k == 1) begin
      checks++;
      if (k != 1 || valid1 !== 1'b1 || ferr1 !== 1'b0) begin
        errors++;
        $display("FAIL valid1 cyc=%0d got valid=%0b ferr=%0b want valid=%0b", cyc, valid1, ferr1, k == 1);
      end else if (data1 !== exp_word[cyc]) begin
        errors++;
        $display("FAIL data1 cyc=%0d got=%h want=%h", cyc, data1, exp_word[cyc]);
      end
    end
    if (ferr1 === 1'b1 || k == 2) begin
      checks++;
      if (k != 2 || ferr1 !== 1'b1 || valid1 !== 1'b0) begin
        errors++;
        $display("FAIL ferr1 cyc=%0d got ferr=%0b valid=%0b want ferr=%0b", cyc, ferr1, valid1, k == 2);
      end
    end
    if (!rst1 && data1 !== prev_data1) begin
      checks++;
      if (valid1 !== 1'b1) begin
        errors++;
        $display("FAIL data1_hold cyc=%0d got=%h want=%h", cyc, data1, prev_data1);
      end
    end
    prev_data1 = data1;
    if (valid1 === 1'b1) begin got_kind.push_back(1); got_data.push_back(data1); got_cyc.push_back(cyc); end
    if (ferr1 === 1'b1)  begin got_kind.push_back(2); got_data.push_back(data1); got_cyc.push_back(cyc); end
  end

  logic [31:0] v16[$];
  int          nerr16 = 0;
  always @(negedge clk) begin
    if (valid16 === 1'b1) v16.push_back(data16);
    if (ferr16 === 1'b1)  nerr16++;
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle1(input int n);
    rxd1 = 1'b1;
    repeat (n) tick1();
  endtask

  // One frame on rxd1; stop sample lands 9 cycles after the start sample.
  task automatic frame1(input logic [7:0] b, input logic stop);
    int s;
    s = cyc + 1;
    rxd1 = 1'b0;
    tick1();
    for (int i = 7; i >= 0; i--) begin
      rxd1 = b[i];
      tick1();
    end
    rxd1 = stop;
    tick1();
    rxd1 = 1'b1;
    if (stop) begin
      mbytes.push_back(b);
      if (mbytes.size() == 4) begin
        exp_kind[s + 9 + SYNC] = 1;
        exp_word[s + 9 + SYNC] = {mbytes[0], mbytes[1], mbytes[2], mbytes[3]};
        exp_last = {mbytes[0], mbytes[1], mbytes[2], mbytes[3]};
        nexp++;
        mbytes.delete();
      end
    end else begin
      exp_kind[s + 9 + SYNC] = 2;
      nexp++;
      mbytes.delete();
    end
  endtask

  // Word as four frames; a bad frame index ends the word early.
  task automatic word1(input logic [31:0] w, input int mid_gap, input int bad);
    for (int f = 0; f < 4; f++) begin
      logic [7:0] b;
      b = w[31 - 8*f -: 8];
      frame1(b, (f == bad) ? 1'b0 : 1'b1);
      if (f == bad) break;
      if (f < 3) idle1(mid_gap);
    end
  endtask

  task automatic bit16(input logic b);
    rxd16 = b;
    repeat (N16) tick1();
  endtask

  task automatic word16(input logic [31:0] w);
    for (int f = 0; f < 4; f++) begin
      bit16(1'b0);
      for (int i = 7; i >= 0; i--) bit16(w[31 - 8*f - (7 - i)]);
      bit16(1'b1);
    end
    rxd16 = 1'b1;
  endtask

  typedef struct {
    logic [31:0] word;
    int          pre_gap;
    int          bad;
    logic        exp_v;
    logic        exp_e;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[NV];
  int   st[NV];
  int   vc[NV];

  initial begin
    int          k;
    int          c;
    logic [31:0] d;
    bit          prev_bad;

    tbl[0] = '{32'hDEADBEEF, 2, -1, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{32'h01234567, 0, -1, 1'b1, 1'b0, 32'h01234567};
    tbl[2] = '{32'h89ABCDEF, 0, -1, 1'b1, 1'b0, 32'h89ABCDEF};
    tbl[3] = '{32'h12345678, 3,  2, 1'b0, 1'b1, 32'h89ABCDEF};
    tbl[4] = '{32'hCAFEF00D, 1, -1, 1'b1, 1'b0, 32'hCAFEF00D};
    tbl[5] = '{32'h00FF00FF, 0,  0, 1'b0, 1'b1, 32'hCAFEF00D};
    tbl[6] = '{32'hFFFFFFFF, 1, -1, 1'b1, 1'b0, 32'hFFFFFFFF};
    tbl[7] = '{32'h13572468, 2,  3, 1'b0, 1'b1, 32'hFFFFFFFF};
    tbl[8] = '{32'h80000001, 1, -1, 1'b1, 1'b0, 32'h80000001};

    rst1 = 1'b0; rst16 = 1'b0; rxd1 = 1'b1; rxd16 = 1'b1;
    #1;
    rst1 = 1'b1; rst16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data1",  data1,  32'h0);
    check("rst_valid1", 32'(valid1), 32'h0);
    check("rst_ferr1",  32'(ferr1),  32'h0);
    check("rst_busy1",  32'(busy1),  32'h0);
    check("rst_data16", data16, 32'h0);
    check("rst_busy16", 32'(busy16), 32'h0);
    rst1 = 1'b0; rst16 = 1'b0;

    // Directed table on the 1 clk/bit instance.
    for (int i = 0; i < NV; i++) begin
      st[i] = cyc + tbl[i].pre_gap + 1;
      idle1(tbl[i].pre_gap);
      word1(tbl[i].word, 0, tbl[i].bad);
    end
    idle1(8);
    for (int i = 0; i < NV; i++) begin
      vc[i] = 0;
      if (got_kind.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tbl%0d_event got=none want=%0d", i, tbl[i].exp_v ? 1 : 2);
      end else begin
        k = got_kind.pop_front();
        d = got_data.pop_front();
        c = got_cyc.pop_front();
        vc[i] = c;
        check($sformatf("tbl%0d_kind", i), k, tbl[i].exp_v ? 32'd1 : 32'd2);
        if (tbl[i].exp_v) check($sformatf("tbl%0d_data", i), d, tbl[i].exp_data);
      end
    end
    check("tbl_extra_events", 32'(got_kind.size()), 32'd0);
    check("lat_first_word", vc[0] - st[0], 39 + SYNC);
    check("b2b_spacing", vc[2] - vc[1], 40);
    check("tbl_final_data", data1, tbl[NV-1].exp_data);

    // Randomized words, gaps and stop-bit faults against the frame model.
    got_kind.delete(); got_data.delete(); got_cyc.delete();
    nexp = 0;
    prev_bad = 1'b0;
    for (int n = 0; n < 30; n++) begin
      int pre;
      int bad;
      pre = $urandom_range(0, 3);
      if (prev_bad && pre == 0) pre = 1;
      bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      idle1(pre);
      word1($urandom, $urandom_range(0, 2), bad);
      prev_bad = (bad >= 0);
    end
    idle1(8);
    check("rand_event_count", 32'(got_kind.size()), 32'(nexp));
    check("rand_final_data", data1, exp_last);

    // Reset, then line held low: exactly one error, then a clean word.
    rst1 = 1'b1;
    tick1();
    mbytes.delete();
    got_kind.delete(); got_data.delete(); got_cyc.delete();
    exp_kind[cyc + 1 + 9 + SYNC] = 2;
    rst1 = 1'b0;
    rxd1 = 1'b0;
    repeat (100) tick1();
    idle1(1);
    word1(32'h600DF00D, 0, -1);
    idle1(8);
    check("low_line_events", 32'(got_kind.size()), 32'd2);
    if (got_kind.size() == 2) begin
      check("low_line_err", got_kind[0], 32'd2);
      check("low_line_word", got_data[1], 32'h600DF00D);
    end
    check("low_line_data", data1, 32'h600DF00D);

    // 16 clks/bit: a word, then reset mid-frame, then an all-zero word.
    word16(32'hA5A55A5A);
    repeat (8) tick1();
    check("n16_first_count", 32'(v16.size()), 32'd1);
    check("n16_first_data", data16, 32'hA5A55A5A);
    v16.delete();
    bit16(1'b0); bit16(1'b1); bit16(1'b0);
    rxd16 = 1'b1;
    repeat (5) tick1();
    check("n16_busy_midframe", 32'(busy16), 32'd1);
    rst16 = 1'b1;
    #1;
    check("n16_rst_data", data16, 32'h0);
    check("n16_rst_busy", 32'(busy16), 32'd0);
    check("n16_rst_valid", 32'(valid16), 32'd0);
    repeat (2) tick1();
    rst16 = 1'b0;
    repeat (4) tick1();
    word16(32'h00000000);
    repeat (8) tick1();
    check("n16_zero_count", 32'(v16.size()), 32'd1);
    if (v16.size() > 0) check("n16_zero_data", v16[0], 32'h0);
    check("n16_zero_err", 32'(nerr16), 32'd0);

    // 16 clks/bit: short low glitch must be rejected at the mid-bit sample.
    v16.delete();
    nerr16 = 0;
    rxd16 = 1'b0;
    repeat (3) tick1();
    rxd16 = 1'b1;
    tick1();
    check("glitch_busy_early", 32'(busy16), 32'd1);
    repeat (10) tick1();
    check("glitch_busy_late", 32'(busy16), 32'd0);
    repeat (300) tick1();
    check("glitch_no_valid", 32'(v16.size()), 32'd0);
    check("glitch_no_err", 32'(nerr16), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
